acs_path_metric_unit: RTL and testbench
=======================================

// Module: acs_path_metric_unit
// PURPOSE
//  Add-compare-select stage that sits directly after the branch metric unit in the Viterbi decoder.
//  Consumes the 16 registered 2-bit branch Hamming distances, one trellis step per valid cycle.
//  Updates 8 normalised path metrics and emits one survivor-decision bit per state.
//  Also emits the index of the best state, for the traceback stage.
// PARAMETERS
//  PMW        6   path-metric width in bits (range 4..10)
//  INIT_BIAS  16  metric loaded into states 1..7 on start; must be <= 2^PMW-1
// PORTS
//  clock       input   1      rising-edge clock
//  reset       input   1      synchronous, active-low reset
//  start       input   1      one-cycle pulse: load initial metrics, enter RUN
//  stop        input   1      one-cycle pulse: return to IDLE, hold metrics
//  bm_valid    input   1      bm_flat valid this cycle (BMU enable delayed 1 cycle)
//  bm_flat     input   32     HDk at bits [2k-1:2k-2], k=1..16
//  pm_flat     output  8*PMW  path metric of state s at bits [PMW*(s+1)-1:PMW*s]
//  dec         output  8      dec[s]=1 -> state s survivor came from odd predecessor
//  dec_valid   output  1      dec/pm_flat/best_state updated this cycle
//  best_state  output  3      state with minimum metric, lowest index on tie
//  step_cnt    output  16     number of ACS steps since last start, wraps at 65535->0
//  busy        output  1      1 in RUN
// BEHAVIOUR
//  Reset (reset==0 at posedge) state and outputs:
//   - FSM goes to IDLE.
//   - pm_flat, dec, best_state, step_cnt, dec_valid and busy all go to 0.
//  Trellis mapping:
//   - State s is 3 bits; next state ns has predecessors p0={ns[1:0],0} and p1={ns[1:0],1}.
//   - Branch p0->ns uses HD(2*ns+1); branch p1->ns uses HD(2*ns+2).
//  ACS step (RUN && bm_valid), computed from the registered metrics:
//   - a=pm[p0]+HD(2ns+1) and b=pm[p1]+HD(2ns+2), both at PMW+1 bits.
//   - new[ns]=min(a,b); dec[ns]=(b<a); a tie selects p0, so dec=0.
//   - m=min over ns of new[ns].
//   - pm[ns] <= new[ns]-m, saturated to 2^PMW-1 if the result exceeds it.
//   - best_state <= lowest ns with new[ns]==m.
//   - step_cnt <= step_cnt+1; dec_valid <= 1.
//   - Latency: 1 cycle from bm_valid to dec_valid; back-to-back bm_valid is supported every cycle.
//  When no step occurs:
//   - dec_valid <= 0.
//   - pm_flat, dec, best_state and step_cnt hold.
//  FSM:
//   - IDLE -start-> RUN: pm[0]<=0, pm[1..7]<=INIT_BIAS, step_cnt<=0, dec<=0, best_state<=0, dec_valid<=0.
//   - RUN -stop-> IDLE: metrics hold, dec_valid<=0.
//   - RUN -start-> RUN: re-initialise exactly as on IDLE->start.
//   - busy=1 exactly in RUN.
//  Boundary and simultaneous events:
//   - bm_valid in IDLE is ignored.
//   - start together with bm_valid: start wins, bm discarded, no step.
//   - stop together with bm_valid: step is NOT taken; go to IDLE.
//   - start together with stop: start wins.
//   - reset asserted mid-RUN: full clear next edge, any step in flight discarded.
//   - Normalisation guarantees min(pm)==0 after every step.
//   - Saturation applies only when spread exceeds 2^PMW-1; the saturated value is held, never wrapped.
// TESTING
//  1 reset=0 two cycles: all outputs 0, busy=0 -> after start, pm={0,16,16,16,16,16,16,16}, busy=1, step_cnt=0.
//  2 start, then one step with all HD=0 -> pm[0]=pm[4]=0, others 16; dec=0x00; best_state=0; dec_valid high exactly 1 cycle after bm_valid.
//  3 start, then 8 steps of the Rx=00 pattern (HD1=0, HD2=2, HD3=1 ...) -> pm[0]=0 every step, best_state=0, step_cnt=8; compare dec against the bench model.
//  4 all pm equal, HD(2ns+1)==HD(2ns+2) for every ns -> dec=0x00 (tie selects p0) and best_state=0.
//  5 PMW=4, INIT_BIAS=15, HD favouring state 0 for 10 steps -> no metric exceeds 15 and none wraps; min(pm)==0 after every step.
//  6 Sequencing checks, in turn:
//    - start+bm_valid same cycle -> no step.
//    - stop+bm_valid -> no step, busy=0.
//    - bm_valid in IDLE -> dec_valid stays 0.
//    - reset mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/acs_path_metric_unit.sv
// Viterbi add-compare-select stage: 8-state trellis, normalised saturating path metrics,
// per-state survivor decisions and best-state index for traceback.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | metrics held, branch metrics ignored
//  ST_RUN   | one ACS step per bm_valid cycle
module acs_path_metric_unit #(
    parameter int PMW       = 6,
    parameter int INIT_BIAS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 bm_valid,
    input  logic [31:0]          bm_flat,
    output logic [8*PMW-1:0]     pm_flat,
    output logic [7:0]           dec,
    output logic                 dec_valid,
    output logic [2:0]           best_state,
    output logic [15:0]          step_cnt,
    output logic                 busy
);

    localparam logic [0:0]     ST_IDLE = 1'b0;
    localparam logic [0:0]     ST_RUN  = 1'b1;
    localparam logic [PMW-1:0] PM_MAX  = '1;
    localparam logic [PMW-1:0] PM_BIAS = PMW'(INIT_BIAS);

    logic [0:0]     state;
    logic [PMW-1:0] pm       [8];
    logic [PMW:0]   a_sum    [8];
    logic [PMW:0]   b_sum    [8];
    logic [PMW:0]   new_pm   [8];
    logic [PMW:0]   diff     [8];
    logic [PMW-1:0] pm_nxt   [8];
    logic [PMW:0]   m_min;
    logic [7:0]     dec_nxt;
    logic [2:0]     best_nxt;

    // Predecessors of ns are {ns[1:0],0} and {ns[1:0],1}; their branches use HD(2ns+1), HD(2ns+2).
    always_comb begin
        dec_nxt = '0;
        for (int ns = 0; ns < 8; ns++) begin
            a_sum[ns]  = (PMW+1)'(pm[2*(ns%4)])   + (PMW+1)'(bm_flat[4*ns +: 2]);
            b_sum[ns]  = (PMW+1)'(pm[2*(ns%4)+1]) + (PMW+1)'(bm_flat[4*ns+2 +: 2]);
            dec_nxt[ns] = (b_sum[ns] < a_sum[ns]);
            new_pm[ns] = dec_nxt[ns] ? b_sum[ns] : a_sum[ns];
        end

        m_min = new_pm[0];
        for (int ns = 1; ns < 8; ns++) begin
            if (new_pm[ns] < m_min) begin
                m_min = new_pm[ns];
            end
        end

        best_nxt = 3'd0;
        for (int ns = 7; ns >= 0; ns--) begin
            if (new_pm[ns] == m_min) begin
                best_nxt = 3'(ns);
            end
        end

        for (int ns = 0; ns < 8; ns++) begin
            diff[ns]   = new_pm[ns] - m_min;
            pm_nxt[ns] = diff[ns][PMW] ? PM_MAX : diff[ns][PMW-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            dec        <= '0;
            dec_valid  <= 1'b0;
            best_state <= '0;
            step_cnt   <= '0;
            for (int s = 0; s < 8; s++) begin
                pm[s] <= '0;
            end
        end else if (start) begin
            state      <= ST_RUN;
            dec        <= '0;
            dec_valid  <= 1'b0;
            best_state <= '0;
            step_cnt   <= '0;
            pm[0]      <= '0;
            for (int s = 1; s < 8; s++) begin
                pm[s] <= PM_BIAS;
            end
        end else if (state == ST_RUN && stop) begin
            state     <= ST_IDLE;
            dec_valid <= 1'b0;
        end else if (state == ST_RUN && bm_valid) begin
            dec        <= dec_nxt;
            dec_valid  <= 1'b1;
            best_state <= best_nxt;
            step_cnt   <= step_cnt + 16'd1;
            for (int s = 0; s < 8; s++) begin
                pm[s] <= pm_nxt[s];
            end
        end else begin
            dec_valid <= 1'b0;
        end
    end

    always_comb begin
        pm_flat = '0;
        for (int s = 0; s < 8; s++) begin
            pm_flat[PMW*s +: PMW] = pm[s];
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_acs_path_metric_unit.sv
// Bench for acs_path_metric_unit: two instances (PMW=6/bias 16 and PMW=4/bias 15) driven
// with shared directed vectors and checked each cycle against an arithmetic trellis model.
module tb_acs_path_metric_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        bm_valid = 1'b0;
    logic [31:0] bm_flat = '0;

    logic [47:0] pmf0;
    logic [31:0] pmf1;
    logic [7:0]  dec0, dec1;
    logic        dv0, dv1, busy0, busy1;
    logic [2:0]  best0, best1;
    logic [15:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int mpm   [2][8];
    int mdec  [2];
    int mbest [2];
    int mcnt  [2];
    bit mdv   [2];
    bit mrun  [2];
    int mmax  [2] = '{63, 15};
    int mbias [2] = '{16, 15};

    acs_path_metric_unit #(.PMW(6), .INIT_BIAS(16)) u0 (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .bm_valid(bm_valid), .bm_flat(bm_flat), .pm_flat(pmf0), .dec(dec0),
        .dec_valid(dv0), .best_state(best0), .step_cnt(cnt0), .busy(busy0));

    acs_path_metric_unit #(.PMW(4), .INIT_BIAS(15)) u1 (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .bm_valid(bm_valid), .bm_flat(bm_flat), .pm_flat(pmf1), .dec(dec1),
        .dec_valid(dv1), .best_state(best1), .step_cnt(cnt1), .busy(busy1));

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hd(input logic [31:0] bm, input int k);
        return int'((bm >> (2*k-2)) & 32'h3);
    endfunction

    // Trellis model: plain integer arithmetic over the state table.
    task automatic model_tick(input int u);
        int nw [8];
        int a, b, m, d;
        if (!reset) begin
            for (int s = 0; s < 8; s++) mpm[u][s] = 0;
            mdec[u] = 0; mbest[u] = 0; mcnt[u] = 0; mdv[u] = 0; mrun[u] = 0;
        end else if (start) begin
            mpm[u][0] = 0;
            for (int s = 1; s < 8; s++) mpm[u][s] = mbias[u];
            mdec[u] = 0; mbest[u] = 0; mcnt[u] = 0; mdv[u] = 0; mrun[u] = 1;
        end else if (mrun[u] && stop) begin
            mrun[u] = 0; mdv[u] = 0;
        end else if (mrun[u] && bm_valid) begin
            d = 0;
            for (int ns = 0; ns < 8; ns++) begin
                a = mpm[u][(ns % 4) * 2]     + hd(bm_flat, 2*ns + 1);
                b = mpm[u][(ns % 4) * 2 + 1] + hd(bm_flat, 2*ns + 2);
                if (b < a) begin nw[ns] = b; d += (1 << ns); end
                else nw[ns] = a;
            end
            m = nw[0];
            for (int ns = 1; ns < 8; ns++) if (nw[ns] < m) m = nw[ns];
            mbest[u] = -1;
            for (int ns = 0; ns < 8; ns++) begin
                if (mbest[u] < 0 && nw[ns] == m) mbest[u] = ns;
                mpm[u][ns] = (nw[ns] - m > mmax[u]) ? mmax[u] : nw[ns] - m;
            end
            mdec[u] = d;
            mcnt[u] = (mcnt[u] + 1) % 65536;
            mdv[u]  = 1;
        end else begin
            mdv[u] = 0;
        end
    endtask

    always @(posedge clock) begin
        model_tick(0);
        model_tick(1);
    end

    always @(negedge clock) begin
        if (chk_en) begin
            int mn;
            for (int s = 0; s < 8; s++) begin
                chk($sformatf("u0_pm%0d", s), int'(pmf0[6*s +: 6]), mpm[0][s]);
                chk($sformatf("u1_pm%0d", s), int'(pmf1[4*s +: 4]), mpm[1][s]);
            end
            chk("u0_dec",  int'(dec0),  mdec[0]);
            chk("u1_dec",  int'(dec1),  mdec[1]);
            chk("u0_best", int'(best0), mbest[0]);
            chk("u1_best", int'(best1), mbest[1]);
            chk("u0_cnt",  int'(cnt0),  mcnt[0]);
            chk("u1_cnt",  int'(cnt1),  mcnt[1]);
            chk("u0_dv",   int'(dv0),   int'(mdv[0]));
            chk("u1_dv",   int'(dv1),   int'(mdv[1]));
            chk("u0_busy", int'(busy0), int'(mrun[0]));
            chk("u1_busy", int'(busy1), int'(mrun[1]));
            if (dv1) begin
                mn = 99;
                for (int s = 0; s < 8; s++) if (int'(pmf1[4*s +: 4]) < mn) mn = int'(pmf1[4*s +: 4]);
                chk("u1_min_pm_zero", mn, 0);
            end
        end
    end

    // Called at a falling edge: apply inputs, return at the next falling edge.
    task automatic drive(input bit st, input bit sp, input bit bv, input logic [31:0] bm);
        start = st; stop = sp; bm_valid = bv; bm_flat = bm;
        @(negedge clock);
    endtask

    localparam logic [31:0] BM_ZERO = 32'h0000_0000;
    localparam logic [31:0] BM_RX00 = 32'h6E27_9D58;
    localparam logic [31:0] BM_TIE  = 32'hFA50_FA50;
    localparam logic [31:0] BM_SAT  = 32'hFFFF_FFF0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 0, BM_ZERO);
        drive(0, 0, 0, BM_ZERO);
        chk("rst_pm",   int'(pmf0 == '0), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_dv",   int'(dv0), 0);
        chk("rst_cnt",  int'(cnt0), 0);
        chk_en = 1'b1;
        reset = 1'b1;

        drive(1, 0, 0, BM_ZERO);
        chk("start_pm0", int'(pmf0[5:0]), 0);
        chk("start_pm1", int'(pmf0[11:6]), 16);
        chk("start_u1_pm7", int'(pmf1[31:28]), 15);
        chk("start_busy", int'(busy0), 1);
        chk("start_cnt", int'(cnt0), 0);

        drive(0, 0, 1, BM_ZERO);
        chk("zero_dv", int'(dv0), 1);
        chk("zero_pm4", int'(pmf0[29:24]), 0);
        chk("zero_pm1", int'(pmf0[11:6]), 16);
        chk("zero_dec", int'(dec0), 0);
        chk("zero_best", int'(best0), 0);
        drive(0, 0, 0, BM_ZERO);
        chk("zero_dv_drop", int'(dv0), 0);

        drive(1, 0, 0, BM_ZERO);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, BM_RX00);
            chk("rx00_pm0", int'(pmf0[5:0]), 0);
            chk("rx00_best", int'(best0), 0);
        end
        chk("rx00_cnt", int'(cnt0), 8);

        drive(1, 0, 0, BM_ZERO);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, BM_ZERO);
        chk("equal_pm", int'(pmf0 == '0), 1);
        drive(0, 0, 1, BM_TIE);
        chk("tie_dec", int'(dec0), 0);
        chk("tie_best", int'(best0), 0);
        chk("tie_pm1", int'(pmf0[11:6]), 1);

        drive(1, 0, 0, BM_ZERO);
        drive(0, 0, 1, BM_SAT);
        chk("sat_u1_pm4", int'(pmf1[19:16]), 3);
        chk("sat_u1_pm1", int'(pmf1[7:4]), 15);
        chk("sat_u0_pm1", int'(pmf0[11:6]), 19);
        for (int i = 0; i < 9; i++) drive(0, 0, 1, BM_SAT);
        chk("sat_cnt", int'(cnt1), 10);

        drive(1, 0, 1, BM_RX00);
        chk("start_bv_cnt", int'(cnt0), 0);
        chk("start_bv_dv", int'(dv0), 0);
        drive(0, 0, 1, BM_RX00);
        chk("step_cnt1", int'(cnt0), 1);
        drive(0, 1, 1, BM_RX00);
        chk("stop_bv_dv", int'(dv0), 0);
        chk("stop_bv_busy", int'(busy0), 0);
        chk("stop_bv_cnt", int'(cnt0), 1);
        drive(0, 0, 1, BM_RX00);
        chk("idle_bv_dv", int'(dv0), 0);
        chk("idle_bv_cnt", int'(cnt0), 1);
        drive(1, 1, 0, BM_ZERO);
        chk("start_stop_busy", int'(busy0), 1);
        drive(0, 0, 1, BM_SAT);
        reset = 1'b0;
        drive(0, 0, 1, BM_SAT);
        chk("midrst_pm", int'(pmf0 == '0), 1);
        chk("midrst_dec", int'(dec0), 0);
        chk("midrst_best", int'(best0), 0);
        chk("midrst_cnt", int'(cnt0), 0);
        chk("midrst_dv", int'(dv0), 0);
        chk("midrst_busy", int'(busy0), 0);
        reset = 1'b1;
        drive(0, 0, 0, BM_ZERO);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
